cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step/halt controller that sequences the one-cycle CPU on the demo board. It generates a single-cycle clock-enable pulse for the CPU core from the 50 MHz board clock. Three pushbuttons drive it: free-run at a fixed tick rate, single-step, and halt. A PC breakpoint comparator stops free-run before the matching instruction executes. It replaces the bare enable-driven divider in front of the core and exposes its state for LED display.

## Interface
- WIDTH, 8, PC width in bits
- TICK_DIV, 50_000_000, clk cycles per run-mode step (1 Hz at 50 MHz); minimum 2
- DEBOUNCE, 500_000, cycles a synchronized button level must be stable to be accepted; minimum 1

- clk  in  1  board clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- btn_run  in  1  raw run button, active-high, asynchronous to clk
- btn_step  in  1  raw single-step button, active-high, asynchronous
- btn_halt  in  1  raw halt button, active-high, asynchronous
- bp_en  in  1  breakpoint enable (switch, synchronized internally)
- bp_addr  in  WIDTH  breakpoint PC value (quasi-static switch input)
- pc  in  WIDTH  current CPU program counter
- cpu_en  out  1  one-cycle pulse; the CPU advances one instruction per pulse
- state  out  2  0=HALT, 1=RUN, 2=STEP, 3=BREAK
- bp_hit  out  1  high while in BREAK
- tick_led  out  1  toggles on every cpu_en pulse

## Operation
- Each button passes through a 2-FF synchronizer and then a stability counter. The debounced level takes the synchronized value after DEBOUNCE consecutive equal samples; any change restarts the count.
- A press event is a one-cycle pulse on a 0->1 transition of the debounced level. Releases generate nothing.
- Simultaneous press events are prioritized halt > step > run; lower-priority events in the same cycle are discarded.
- HALT: step -> STEP; run -> RUN (tick counter cleared); halt ignored.
- STEP: lasts exactly one cycle, with cpu_en=1, then goes to HALT. Events arriving while in STEP are discarded.
- RUN: the tick counter counts 0..TICK_DIV-1 and wraps to 0. At terminal count:
  - if bp_en=1, pc==bp_addr and skip=0: go to BREAK with no pulse.
  - otherwise: cpu_en=1 for that cycle and skip is cleared.
- RUN transitions: halt -> HALT (counter cleared, no pulse in that cycle even at terminal count); step is ignored.
- BREAK: run -> RUN with skip=1 and counter cleared, so the matching instruction executes on the next tick; step -> STEP (one pulse, then HALT); halt -> HALT.
- skip is set only on BREAK->RUN and cleared on the next cpu_en pulse or on entry to HALT.
- tick_led flips on every cycle in which cpu_en=1.
- Reset values: state=HALT, cpu_en=0, bp_hit=0, tick_led=0, tick counter=0, skip=0, synchronizers, debounce counters and debounced levels=0.
- Reset asserted mid-pulse or mid-count forces these values immediately; no pulse is issued after deassertion until a new press event.
- Tick counter width is ceil(log2(TICK_DIV)). Debounce counter width is ceil(log2(DEBOUNCE+1)).

## Timing
- Button edge to press event: 2 sync cycles + DEBOUNCE cycles + 1 edge-detect cycle.
- Press event in cycle N -> state register updates at the edge ending cycle N; the new state is visible in cycle N+1.
- Step: cpu_en is high in cycle N+1, and state reads HALT in cycle N+2.
- Run from HALT: the first cpu_en occurs TICK_DIV cycles after RUN entry, then every TICK_DIV cycles. cpu_en is never high for two consecutive cycles.
- The breakpoint compare uses pc as sampled in the terminal-count cycle. BREAK is entered at the edge ending that cycle, and bp_hit rises in the following cycle.
- All outputs are registered.

## Test plan
- Reset/idle (TICK_DIV=4, DEBOUNCE=3): hold rst_n=0, then release with no buttons -> state=0, cpu_en never high for 100 cycles.
- Single step: pulse btn_step for 10 cycles -> exactly one cpu_en pulse, state 0->2->0, tick_led=1; a 2-cycle glitch on btn_step -> no pulse.
- Free run: press run -> cpu_en every 4 cycles (first one 4 cycles after RUN entry); press halt -> pulses stop, state=0, counter restarts on the next run.
- Breakpoint: bp_en=1, bp_addr=8'h05, pc increments on each cpu_en from 0 -> pulses occur for pc=0..4, then state=3 and bp_hit=1 with pc=5. Press run -> pulse at pc=5, then continue to pc=6; press step in BREAK instead -> one pulse, state=0.
- Priority: assert run, step and halt with identical debounced edges in HALT -> no transition (halt wins and is ignored). Assert step and run together in HALT -> STEP, single pulse.
- Async reset in RUN at counter=3 -> cpu_en=0 and state=0 immediately; no pulse after release.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Button, breakpoint and CPU-facing signals of the run/step/halt controller.
// The board side (master) drives buttons, switches and pc; the controller (slave) drives the rest.
interface cpu_run_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             btn_run;
    logic             btn_step;
    logic             btn_halt;
    logic             bp_en;
    logic [WIDTH-1:0] bp_addr;
    logic [WIDTH-1:0] pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;
    logic             tick_led;

    modport master (
        output btn_run, btn_step, btn_halt, bp_en, bp_addr, pc,
        input  cpu_en, state, bp_hit, tick_led
    );

    modport slave (
        input  btn_run, btn_step, btn_halt, bp_en, bp_addr, pc,
        output cpu_en, state, bp_hit, tick_led
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing a one-cycle clock enable for the demo CPU,
// with debounced pushbuttons and a PC breakpoint that stops free-run before the match executes.
//
// state   | meaning
// HALT    | idle, waiting for step or run
// RUN     | free-run, one cpu_en per TICK_DIV cycles
// STEP    | single cycle carrying the step pulse, then HALT
// BREAK   | stopped on breakpoint match, bp_hit high
module cpu_run_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    // button index: 0 = run, 1 = step, 2 = halt
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [2:0]    level_d;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];
    logic          bp_sync1;
    logic          bp_sync2;

    logic          ev_run;
    logic          ev_step;
    logic          ev_halt;
    logic          bp_match;
    logic [WIDTH-1:0] pc_cur;
    logic [WIDTH-1:0] bp_cur;

    state_t        fsm_state;
    logic [TW-1:0] tick_cnt;
    logic          skip;
    logic          cpu_en_r;
    logic          bp_hit_r;
    logic          tick_led_r;

    assign btn_raw = {bus.btn_halt, bus.btn_step, bus.btn_run};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            level_d  <= '0;
            bp_sync1 <= 1'b0;
            bp_sync2 <= 1'b0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            level_d  <= level;
            bp_sync1 <= bus.bp_en;
            bp_sync2 <= bp_sync1;
            // a sample equal to the accepted level restarts the stability count
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press    = level & ~level_d;
    assign ev_halt  = press[2];
    assign ev_step  = press[1] & ~press[2];
    assign ev_run   = press[0] & ~press[1] & ~press[2];

    assign pc_cur   = bus.pc;
    assign bp_cur   = bus.bp_addr;
    assign bp_match = bp_sync2 && (pc_cur == bp_cur) && !skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state  <= S_HALT;
            tick_cnt   <= '0;
            skip       <= 1'b0;
            cpu_en_r   <= 1'b0;
            bp_hit_r   <= 1'b0;
            tick_led_r <= 1'b0;
        end else begin
            cpu_en_r <= 1'b0;
            case (fsm_state)
                S_HALT: begin
                    tick_cnt <= '0;
                    skip     <= 1'b0;
                    if (ev_step) begin
                        fsm_state  <= S_STEP;
                        cpu_en_r   <= 1'b1;
                        tick_led_r <= ~tick_led_r;
                    end else if (ev_run) begin
                        fsm_state <= S_RUN;
                    end
                end
                S_STEP: begin
                    fsm_state <= S_HALT;
                    skip      <= 1'b0;
                end
                S_RUN: begin
                    if (ev_halt) begin
                        fsm_state <= S_HALT;
                        tick_cnt  <= '0;
                        skip      <= 1'b0;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bp_match) begin
                            fsm_state <= S_BREAK;
                            bp_hit_r  <= 1'b1;
                        end else begin
                            cpu_en_r   <= 1'b1;
                            tick_led_r <= ~tick_led_r;
                            skip       <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (ev_halt) begin
                        fsm_state <= S_HALT;
                        bp_hit_r  <= 1'b0;
                    end else if (ev_step) begin
                        fsm_state  <= S_STEP;
                        bp_hit_r   <= 1'b0;
                        cpu_en_r   <= 1'b1;
                        tick_led_r <= ~tick_led_r;
                    end else if (ev_run) begin
                        // skip lets the matched instruction execute on the next tick
                        fsm_state <= S_RUN;
                        bp_hit_r  <= 1'b0;
                        skip      <= 1'b1;
                        tick_cnt  <= '0;
                    end
                end
                default: fsm_state <= S_HALT;
            endcase
        end
    end

    assign bus.cpu_en   = cpu_en_r;
    assign bus.state    = fsm_state;
    assign bus.bp_hit   = bp_hit_r;
    assign bus.tick_led = tick_led_r;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a CPU model advances pc on every cpu_en, and each
// expected pulse (its pc value) is queued when stimulus is driven and checked when the pulse appears.
module tb_cpu_run_ctrl;
    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cpu_run_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cpu_run_ctrl #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_pc_q [$];
    logic [WIDTH-1:0] pc_v = '0;
    logic tick_exp = 1'b0;
    logic prev_en  = 1'b0;
    int hold_run  = 0;
    int hold_step = 0;
    int hold_halt = 0;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // one cycle per iteration: monitor pulses at the negedge, then age button holds
    task automatic tick(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.cpu_en === 1'b1) begin
                chk("pulse_expected", 32'(exp_pc_q.size() != 0), 32'd1);
                chk("no_back_to_back", 32'(prev_en), 32'd0);
                if (exp_pc_q.size() != 0) chk("pulse_pc", 32'(pc_v), 32'(exp_pc_q.pop_front()));
                tick_exp = ~tick_exp;
                chk("tick_led", 32'(bus.tick_led), 32'(tick_exp));
                pc_v   = pc_v + 1'b1;
                bus.pc = pc_v;
            end
            prev_en = (bus.cpu_en === 1'b1);
            if (hold_run > 0) begin
                hold_run--;
                if (hold_run == 0) bus.btn_run = 1'b0;
            end
            if (hold_step > 0) begin
                hold_step--;
                if (hold_step == 0) bus.btn_step = 1'b0;
            end
            if (hold_halt > 0) begin
                hold_halt--;
                if (hold_halt == 0) bus.btn_halt = 1'b0;
            end
        end
    endtask

    task automatic press(input int which, input int len);
        case (which)
            0:       begin bus.btn_run  = 1'b1; hold_run  = len; end
            1:       begin bus.btn_step = 1'b1; hold_step = len; end
            default: begin bus.btn_halt = 1'b1; hold_halt = len; end
        endcase
    endtask

    task automatic wait_state(input logic [1:0] want, input int budget, input string tag);
        int k;
        k = 0;
        while (bus.state !== want && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(bus.state), 32'(want));
    endtask

    task automatic wait_pulse(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (bus.cpu_en !== 1'b1 && cycles < budget);
    endtask

    initial begin
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.btn_halt = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 8'h05;
        bus.pc       = pc_v;

        // reset and idle
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'(ST_HALT));
        chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
        chk("rst_tick_led", 32'(bus.tick_led), 32'd0);
        rst_n = 1'b1;
        tick(100);
        chk("idle_state", 32'(bus.state), 32'(ST_HALT));

        // single step, then a glitch too short to pass the debouncer
        exp_pc_q.push_back(pc_v);
        press(1, 10);
        wait_state(ST_STEP, 30, "step_enter");
        chk("step_pulse", 32'(bus.cpu_en), 32'd1);
        tick(1);
        chk("step_back_halt", 32'(bus.state), 32'(ST_HALT));
        tick(20);
        chk("step_tick_led", 32'(bus.tick_led), 32'd1);
        chk("step_drained", 32'(exp_pc_q.size()), 32'd0);
        press(1, 2);
        tick(30);
        chk("glitch_state", 32'(bus.state), 32'(ST_HALT));

        // free run, then halt issued right after a pulse: exactly one more pulse is in flight
        press(0, 10);
        wait_state(ST_RUN, 30, "run_enter");
        for (int k = 0; k < 3; k++) exp_pc_q.push_back(pc_v + WIDTH'(k));
        wait_pulse(20, n); chk("run_first_gap", 32'(n), 32'(TICK_DIV));
        wait_pulse(20, n); chk("run_gap2", 32'(n), 32'(TICK_DIV));
        wait_pulse(20, n); chk("run_gap3", 32'(n), 32'(TICK_DIV));
        exp_pc_q.push_back(pc_v);
        press(2, 10);
        wait_state(ST_HALT, 30, "halt_enter");
        tick(20);
        chk("halt_stays", 32'(bus.state), 32'(ST_HALT));
        chk("halt_drained", 32'(exp_pc_q.size()), 32'd0);

        // rerun: tick counter restarts from zero
        exp_pc_q.push_back(pc_v);
        press(0, 10);
        wait_state(ST_RUN, 30, "rerun_enter");
        wait_pulse(20, n); chk("rerun_first_gap", 32'(n), 32'(TICK_DIV));
        exp_pc_q.push_back(pc_v);
        press(2, 10);
        wait_state(ST_HALT, 30, "rerun_halt");
        tick(10);
        chk("rerun_drained", 32'(exp_pc_q.size()), 32'd0);

        // breakpoint at pc 5, resume with run
        bus.bp_en = 1'b1;
        pc_v = '0;
        bus.pc = pc_v;
        tick(5);
        for (int k = 0; k < 5; k++) exp_pc_q.push_back(WIDTH'(k));
        press(0, 10);
        wait_state(ST_BREAK, 100, "bp_enter");
        chk("bp_hit_high", 32'(bus.bp_hit), 32'd1);
        chk("bp_pc", 32'(pc_v), 32'h05);
        chk("bp_drained", 32'(exp_pc_q.size()), 32'd0);
        tick(12);
        chk("bp_holds", 32'(bus.state), 32'(ST_BREAK));
        exp_pc_q.push_back(8'h05);
        exp_pc_q.push_back(8'h06);
        press(0, 10);
        wait_state(ST_RUN, 30, "bp_resume");
        chk("bp_hit_low", 32'(bus.bp_hit), 32'd0);
        wait_pulse(20, n); chk("resume_gap", 32'(n), 32'(TICK_DIV));
        wait_pulse(20, n); chk("resume_gap2", 32'(n), 32'(TICK_DIV));
        exp_pc_q.push_back(pc_v);
        press(2, 10);
        wait_state(ST_HALT, 30, "resume_halt");
        tick(10);
        chk("resume_drained", 32'(exp_pc_q.size()), 32'd0);

        // breakpoint again, leave it with step
        pc_v = 8'h03;
        bus.pc = pc_v;
        exp_pc_q.push_back(8'h03);
        exp_pc_q.push_back(8'h04);
        press(0, 10);
        wait_state(ST_BREAK, 60, "bp2_enter");
        exp_pc_q.push_back(8'h05);
        press(1, 10);
        wait_state(ST_STEP, 30, "bp2_step");
        chk("bp2_step_pulse", 32'(bus.cpu_en), 32'd1);
        tick(1);
        chk("bp2_halt", 32'(bus.state), 32'(ST_HALT));
        chk("bp2_hit_low", 32'(bus.bp_hit), 32'd0);
        tick(10);
        chk("bp2_drained", 32'(exp_pc_q.size()), 32'd0);
        bus.bp_en = 1'b0;

        // priority: halt masks everything, step beats run
        press(0, 10);
        press(1, 10);
        press(2, 10);
        tick(40);
        chk("prio_all_halt", 32'(bus.state), 32'(ST_HALT));
        exp_pc_q.push_back(pc_v);
        press(0, 10);
        press(1, 10);
        wait_state(ST_STEP, 30, "prio_step");
        tick(1);
        chk("prio_step_halt", 32'(bus.state), 32'(ST_HALT));
        tick(30);
        chk("prio_no_run", 32'(bus.state), 32'(ST_HALT));
        chk("prio_drained", 32'(exp_pc_q.size()), 32'd0);

        // async reset in RUN with the tick counter at its terminal value
        press(0, 10);
        wait_state(ST_RUN, 30, "rst_run_enter");
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'(ST_HALT));
        chk("async_rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("async_rst_tick_led", 32'(bus.tick_led), 32'd0);
        tick_exp = 1'b0;
        prev_en  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("post_rst_state", 32'(bus.state), 32'(ST_HALT));
        chk("post_rst_drained", 32'(exp_pc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
